seg7_scan_capture: RTL



---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_capture.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low digit patterns, decoded codes and capture FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_ILLEGAL = 4'hE;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CHECK   = 2'd1,
        S_PUBLISH = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low g..a segment pattern into a BCD code and illegal flag.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_code_c,
    output logic       o_illegal_c
);

    always_comb begin
        o_code_c    = BCD_ILLEGAL;
        o_illegal_c = 1'b1;
        case (i_pattern)
            SEG_0:     begin o_code_c = 4'd0;      o_illegal_c = 1'b0; end
            SEG_1:     begin o_code_c = 4'd1;      o_illegal_c = 1'b0; end
            SEG_2:     begin o_code_c = 4'd2;      o_illegal_c = 1'b0; end
            SEG_3:     begin o_code_c = 4'd3;      o_illegal_c = 1'b0; end
            SEG_4:     begin o_code_c = 4'd4;      o_illegal_c = 1'b0; end
            SEG_5:     begin o_code_c = 4'd5;      o_illegal_c = 1'b0; end
            SEG_6:     begin o_code_c = 4'd6;      o_illegal_c = 1'b0; end
            SEG_7:     begin o_code_c = 4'd7;      o_illegal_c = 1'b0; end
            SEG_8:     begin o_code_c = 4'd8;      o_illegal_c = 1'b0; end
            SEG_9:     begin o_code_c = 4'd9;      o_illegal_c = 1'b0; end
            SEG_BLANK: begin o_code_c = BCD_BLANK; o_illegal_c = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed active-low 7-segment bus and publishes the number once
// STABLE_FRAMES consecutive identical frames have been seen.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  value_valid,
    output logic                  frame_err,
    output logic                  bus_err
);

    localparam int unsigned BCD_W = 4 * DIGITS;

    state_e             r_state;
    logic [DIGITS-1:0]  r_seen;
    logic [BCD_W-1:0]   r_shadow;
    logic [DIGITS-1:0]  r_shadow_err;
    logic [BCD_W-1:0]   r_cand;
    logic               r_cand_err;
    logic [BCD_W-1:0]   r_prev_cand;
    logic [CNT_W-1:0]   r_count;
    logic               r_published;

    logic [3:0]         w_code;
    logic               w_illegal;
    logic [DIGITS-1:0]  w_sel;
    logic               w_onehot;
    logic               w_take;
    logic [DIGITS-1:0]  w_seen_next;
    logic [BCD_W-1:0]   w_shadow_next;
    logic [DIGITS-1:0]  w_shadow_err_next;
    logic               w_frame_done;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_unused_dp;

    assign w_unused_dp = seg_in[7];

    seg7_pattern_decode u_decode (
        .i_pattern   (seg_in[6:0]),
        .o_code_c    (w_code),
        .o_illegal_c (w_illegal)
    );

    assign w_sel    = ~an_in;
    assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
    assign w_take   = sample_en && w_onehot;

    // Frame contents including this cycle's sample, if any
    always_comb begin
        w_seen_next       = r_seen;
        w_shadow_next     = r_shadow;
        w_shadow_err_next = r_shadow_err;
        if (w_take) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (w_sel[i]) begin
                    w_seen_next[i]          = 1'b1;
                    w_shadow_next[4*i +: 4] = w_code;
                    w_shadow_err_next[i]    = w_illegal;
                end
            end
        end
    end

    // A completed frame outside S_COLLECT stays parked in shadow until we return
    assign w_frame_done = (r_state == S_COLLECT) && (&w_seen_next);

    assign w_cnt_inc  = (r_count >= CNT_W'(STABLE_FRAMES)) ? CNT_W'(STABLE_FRAMES)
                                                          : r_count + CNT_W'(1);
    assign w_cnt_next = ((r_cand == r_prev_cand) && (r_count != '0)) ? w_cnt_inc : CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_COLLECT;
            r_seen       <= '0;
            r_shadow     <= '0;
            r_shadow_err <= '0;
            r_cand       <= '0;
            r_cand_err   <= 1'b0;
            r_prev_cand  <= '0;
            r_count      <= '0;
            r_published  <= 1'b0;
            bcd_out      <= '1;
            value_valid  <= 1'b0;
            frame_err    <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            bus_err     <= sample_en && !w_onehot;
            r_shadow    <= w_shadow_next;

            if (w_frame_done) begin
                r_cand       <= w_shadow_next;
                r_cand_err   <= |w_shadow_err_next;
                r_seen       <= '0;
                r_shadow_err <= '0;
            end else begin
                r_seen       <= w_seen_next;
                r_shadow_err <= w_shadow_err_next;
            end

            case (r_state)
                S_COLLECT: begin
                    if (w_frame_done) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_count     <= w_cnt_next;
                    r_prev_cand <= r_cand;
                    r_state     <= (w_cnt_next == CNT_W'(STABLE_FRAMES)) ? S_PUBLISH : S_COLLECT;
                end
                S_PUBLISH: begin
                    if ((r_cand != bcd_out) || !r_published) begin
                        bcd_out     <= r_cand;
                        frame_err   <= r_cand_err;
                        value_valid <= 1'b1;
                        r_published <= 1'b1;
                    end
                    r_state <= S_COLLECT;
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule
